// File: rtl/serial_slave_port.sv
// serial_slave_port: bit-serial slave endpoint that deserialises address/write data, accesses a local memory
// and serialises read data back; ready tells the arbiter whether a transfer can be accepted or continued.
module serial_slave_port #(
  parameter int ADDR_WIDTH    = 12,
  parameter int DATA_WIDTH    = 8,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic address_in,
  input  logic data_in,
  input  logic valid,
  input  logic write_en,
  input  logic bus_ready,
  output logic data_out,
  output logic ready,
  output logic valid_out
);
  localparam int CW = $clog2((ADDR_WIDTH > DATA_WIDTH ? ADDR_WIDTH : DATA_WIDTH) + 1);
  localparam int WW = $clog2((READ_LATENCY > WRITE_LATENCY ? READ_LATENCY : WRITE_LATENCY) + 1);
  localparam logic [CW-1:0] A_LAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] D_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] D_ALL  = CW'(DATA_WIDTH);
  localparam logic [WW-1:0] RL     = WW'(READ_LATENCY);
  localparam logic [WW-1:0] WL     = WW'(WRITE_LATENCY);
  localparam logic [WW-1:0] W_ONE  = WW'(1);

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, MEM_WR, RWAIT, RDATA} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rd_shift;
  logic [CW-1:0]         bit_cnt;
  logic [WW-1:0]         wait_cnt;
  logic                  wr_lat;
  logic                  accept;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  assign accept = valid & bus_ready;

  // Memory is outside the reset domain so a reset never disturbs stored contents.
  always_ff @(posedge clk)
    if (state == MEM_WR && wait_cnt == WL) mem[addr] <= wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ready     <= 1'b1;
      valid_out <= 1'b0;
      data_out  <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      rd_shift  <= '0;
      bit_cnt   <= '0;
      wait_cnt  <= '0;
      wr_lat    <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (accept) begin
            addr    <= ADDR_WIDTH'({addr, address_in});
            wr_lat  <= write_en;
            bit_cnt <= CW'(1);
            state   <= ADDR;
          end
        ADDR:
          if (accept) begin
            addr <= ADDR_WIDTH'({addr, address_in});
            if (bit_cnt == A_LAST) begin
              bit_cnt  <= '0;
              wait_cnt <= RL;
              ready    <= wr_lat;
              state    <= wr_lat ? WDATA : RWAIT;
            end else bit_cnt <= bit_cnt + 1'b1;
          end
        WDATA:
          if (accept) begin
            wdata <= DATA_WIDTH'({wdata, data_in});
            if (bit_cnt == D_LAST) begin
              bit_cnt  <= '0;
              wait_cnt <= WL;
              ready    <= 1'b0;
              state    <= MEM_WR;
            end else bit_cnt <= bit_cnt + 1'b1;
          end
        MEM_WR:
          if (wait_cnt == W_ONE) begin
            wait_cnt <= '0;
            ready    <= 1'b1;
            state    <= IDLE;
          end else wait_cnt <= wait_cnt - 1'b1;
        RWAIT: begin
          wait_cnt <= wait_cnt - 1'b1;
          if (wait_cnt == W_ONE) begin
            rd_shift <= mem[addr];
            bit_cnt  <= '0;
            state    <= RDATA;
          end
        end
        RDATA:
          if (bit_cnt == D_ALL) begin
            bit_cnt   <= '0;
            valid_out <= 1'b0;
            data_out  <= 1'b0;
            ready     <= 1'b1;
            state     <= IDLE;
          end else if (bus_ready) begin
            valid_out <= 1'b1;
            data_out  <= rd_shift[DATA_WIDTH-1];
            rd_shift  <= rd_shift << 1;
            bit_cnt   <= bit_cnt + 1'b1;
          end else begin
            valid_out <= 1'b0;
            data_out  <= 1'b0;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
